// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer, 4-state debounce FSM per key.
// Define KEY_DEBOUNCE_REPEAT_EN to add held-key auto-repeat on key_press.
module key_debounce_chan #(
  parameter int DB_CYCLES     = 500000
`ifdef KEY_DEBOUNCE_REPEAT_EN
 ,parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          down;
  logic          done;
  logic [CW-1:0] cnt_inc;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt;
  logic          rep_phase;
  logic [RW-1:0] rpt_last;
  // First repeat waits the long delay, later ones the shorter period.
  assign rpt_last = rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
`endif

  assign down    = ~sync[1];
  assign done    = (cnt >= CW'(DB_CYCLES - 1));
  assign cnt_inc = (cnt == CW'(DB_CYCLES)) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt       <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      sync  <= {sync[0], raw_n};
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        RELEASED: begin
          if (down) begin
            if (DB_CYCLES == 1) begin
              state <= PRESSED;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
              cnt   <= CW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!down) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (done) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!down) begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt       <= '0;
            rep_phase <= 1'b0;
`endif
            if (DB_CYCLES == 1) begin
              state <= RELEASED;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= CW'(1);
            end
          end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
            if (rpt == rpt_last) begin
              press     <= 1'b1;
              rpt       <= '0;
              rep_phase <= 1'b1;
            end else begin
              rpt <= rpt + RW'(1);
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (down) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (done) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end
endmodule

module key_debounce #(
  parameter int N_KEYS        = 3,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);
  // Illegal timing parameters build no channels and hold every output low.
  localparam bit PARAMS_OK = (DB_CYCLES >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  if (PARAMS_OK) begin : g_ok
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_debounce_chan #(
        .DB_CYCLES     (DB_CYCLES)
`ifdef KEY_DEBOUNCE_REPEAT_EN
       ,.REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .raw_n (key_n[i]),
        .level (key_level[i]),
        .press (key_press[i]),
        .rel   (key_release[i])
      );
    end
  end else begin : g_bad
    assign key_level   = '0;
    assign key_press   = '0;
    assign key_release = '0;
  end
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with N_KEYS=3, DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_key_debounce;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level, key_press, key_release;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .N_KEYS(N), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  // Advance one rising edge, then settle so sampling and driving sit away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_n = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({key_level, key_press, key_release} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b want all 0", k, key_level, key_press, key_release);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 6) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL held_through_reset edge=%0d got press=%b want %b", k, key_press, (k == 6) ? 3'b111 : 3'b000);
      end
    end
    key_n = 3'b111;
    repeat (12) step();
    checks++;
    if (key_level !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_level got %b want 000", key_level);
    end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] ep, el;
    key_n = 3'b110;
    for (int k = 1; k <= 8; k++) begin
      step();
      ep = (k == 6) ? 3'b001 : 3'b000;
      el = (k >= 6) ? 3'b001 : 3'b000;
      checks++;
      if (key_press !== ep || key_level !== el || key_release !== 3'b000) begin
        errors++;
        $display("FAIL clean_press edge=%0d got prs=%b lvl=%b rel=%b want prs=%b lvl=%b rel=000", k, key_press, key_level, key_release, ep, el);
      end
    end
  endtask

  task automatic test_release_glitch();
    for (int k = 1; k <= 13; k++) begin
      key_n = (k <= 3) ? 3'b111 : 3'b110;
      step();
      checks++;
      if (key_level !== 3'b001 || key_press !== 3'b000 || key_release !== 3'b000) begin
        errors++;
        $display("FAIL release_glitch edge=%0d got lvl=%b prs=%b rel=%b want lvl=001 prs=000 rel=000", k, key_level, key_press, key_release);
      end
    end
  endtask

  task automatic test_release();
    logic [N-1:0] er, el;
    key_n = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      step();
      er = (k == 6) ? 3'b001 : 3'b000;
      el = (k >= 6) ? 3'b000 : 3'b001;
      checks++;
      if (key_release !== er || key_level !== el || key_press !== 3'b000) begin
        errors++;
        $display("FAIL release edge=%0d got rel=%b lvl=%b prs=%b want rel=%b lvl=%b prs=000", k, key_release, key_level, key_press, er, el);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int j = 1; j <= 30; j++) begin
      key_n = 3'b111;
      if (j > 20 || ((j - 1) % 4) < 3) key_n[1] = 1'b0;
      step();
      if (key_press[1]) pulses++;
      checks++;
      if (key_press !== ((j == 26) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL bounce edge=%0d got press=%b want %b", j, key_press, (j == 26) ? 3'b010 : 3'b000);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count got %0d want 1", pulses);
    end
    key_n = 3'b111;
    repeat (10) step();
  endtask

  task automatic test_simultaneous();
    key_n = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 6) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL simultaneous_press edge=%0d got %b want %b", k, key_press, (k == 6) ? 3'b111 : 3'b000);
      end
    end
    key_n = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (key_release !== ((k == 6) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL simultaneous_release edge=%0d got %b want %b", k, key_release, (k == 6) ? 3'b111 : 3'b000);
      end
    end
  endtask

  task automatic test_reset_mid();
    key_n = 3'b110;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({key_level, key_press, key_release} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got lvl=%b prs=%b rel=%b want all 0", key_level, key_press, key_release);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (key_press !== ((k == 6) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL reset_mid_press edge=%0d got %b want %b", k, key_press, (k == 6) ? 3'b001 : 3'b000);
      end
    end
    key_n = 3'b111;
    repeat (10) step();
  endtask

  task automatic test_repeat();
    int got[$];
    int exp[$];
`ifdef KEY_DEBOUNCE_REPEAT_EN
    exp = '{6, 26, 34, 42, 50, 58};
`else
    exp = '{6};
`endif
    key_n = 3'b110;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (key_press[0]) got.push_back(k);
      checks++;
      if (key_press[2:1] !== 2'b00 || key_release !== 3'b000) begin
        errors++;
        $display("FAIL repeat_other edge=%0d got prs=%b rel=%b want prs[2:1]=00 rel=000", k, key_press, key_release);
      end
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL repeat_count got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] != exp[i]) begin
          errors++;
          $display("FAIL repeat_edge idx=%0d got %0d want %0d", i, got[i], exp[i]);
        end
      end
    end
    key_n = 3'b111;
    repeat (10) step();
    checks++;
    if (key_level !== 3'b000) begin
      errors++;
      $display("FAIL repeat_release_level got %b want 000", key_level);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
